// File: rtl/reversal_arbiter.sv
// Two-requester arbiter that feeds one bit-serial word reverser, with round-robin on ties.
// Optional per-requester grant counters are enabled by defining REVERSAL_GRANT_CNT_EN.
module reversal_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy
`ifdef REVERSAL_GRANT_CNT_EN
  ,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic             id_q;
  logic [WIDTH-1:0] src_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;

  logic sel;
  logic idle;
  logic accept;

  // On a tie the requester not served last wins; otherwise whichever is valid.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) sel = ~last_grant_q;
    else                          sel = req1_valid & ~req0_valid;
  end

  assign idle       = (state_q == IDLE);
  // Readys are gated by rst_n so they are low throughout reset.
  assign req0_ready = rst_n & idle & req0_valid & ~sel;
  assign req1_ready = rst_n & idle & req1_valid & sel;
  assign accept     = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      src_q        <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            src_q        <= sel ? req1_data : req0_data;
            id_q         <= sel;
            last_grant_q <= sel;
            result_q     <= '0;
            cnt_q        <= '0;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          result_q <= {result_q[WIDTH-2:0], src_q[0]};
          src_q    <= src_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? result_q : '0;
  assign out_id    = out_valid & id_q;
  assign busy      = ~idle;

`ifdef REVERSAL_GRANT_CNT_EN
  logic [7:0] grant_cnt0_q;
  logic [7:0] grant_cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      if (req0_ready) grant_cnt0_q <= grant_cnt0_q + 8'd1;
      if (req1_ready) grant_cnt1_q <= grant_cnt1_q + 8'd1;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_reversal_arbiter.sv
// Directed bench for reversal_arbiter: latency, tie-break, fairness, backpressure and reset.
module tb_reversal_arbiter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             out_ready;
  logic             busy;
`ifdef REVERSAL_GRANT_CNT_EN
  logic [7:0]       grant_cnt0, grant_cnt1;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  reversal_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .busy       (busy)
`ifdef REVERSAL_GRANT_CNT_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advances until out_valid rises, at most 40 edges; returns edges waited.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  logic [7:0] d0   [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  logic [7:0] e0   [4] = '{8'h80, 8'h40, 8'h20, 8'h10};
  logic [7:0] d1   [4] = '{8'h03, 8'hC0, 8'h55, 8'hE1};
  logic [7:0] e1   [4] = '{8'hC0, 8'h03, 8'hAA, 8'h87};

  initial begin
    int n;
    int k0, k1;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 8'h01;
    req1_valid = 1'b0;
    req1_data  = 8'h00;
    out_ready  = 1'b1;
    #1;
    check("rst_busy",   busy,       0);
    check("rst_ovalid", out_valid,  0);
    check("rst_odata",  out_data,   0);
    check("rst_oid",    out_id,     0);
    check("rst_rdy0",   req0_ready, 0);
    check("rst_rdy1",   req1_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Single request, latency
    check("single_rdy0", req0_ready, 1);
    check("single_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check("single_busy", busy, 1);
    check("single_shift_rdy", req0_ready, 0);
    wait_valid(n);
    check("single_latency", n, WIDTH);
    check("single_data", out_data, 8'h80);
    check("single_id",   out_id,   0);
    tick();
    check("single_back_idle", busy, 0);
    check("single_odata_zero", out_data, 0);

    // Tie after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h0F;
    req1_valid = 1'b1; req1_data = 8'h33;
    #1;
    check("tie_rdy0", req0_ready, 1);
    check("tie_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check("tie_shift_rdy1", req1_ready, 0);
    wait_valid(n);
    check("tie_first_data", out_data, 8'hF0);
    check("tie_first_id",   out_id,   0);
    tick();
    check("tie_no_same_cycle_accept", busy, 0);
    check("tie_rdy1_next", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    wait_valid(n);
    check("tie_second_data", out_data, 8'hCC);
    check("tie_second_id",   out_id,   1);
    tick();

    // Round-robin with both valid continuously
    k0 = 0; k1 = 0;
    req0_valid = 1'b1; req0_data = d0[0];
    req1_valid = 1'b1; req1_data = d1[0];
    #1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        k0++;
        if (k0 < 4) req0_data = d0[k0];
      end else begin
        k1++;
        if (k1 < 4) req1_data = d1[k1];
      end
      wait_valid(n);
      check("rr_id", out_id, i % 2);
      check("rr_data", out_data, (i % 2 == 0) ? e0[i/2] : e1[i/2]);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Backpressure on requester 1
    out_ready  = 1'b0;
    req1_valid = 1'b1; req1_data = 8'hA0;
    #1;
    tick();
    req1_valid = 1'b0;
    wait_valid(n);
    check("bp_latency", n, WIDTH);
    req0_valid = 1'b1; req0_data = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid,  1);
      check("bp_data",  out_data,   8'h05);
      check("bp_id",    out_id,     1);
      check("bp_busy",  busy,       1);
      check("bp_rdy0",  req0_ready, 0);
      check("bp_rdy1",  req1_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_idle", busy, 0);
    check("bp_release_rdy0", req0_ready, 1);

    // Reset during SHIFT (requester 0 granted last, so a tie would favour 1 without reset)
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    check("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy",   busy,      0);
    check("mid_ovalid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("mid_no_output", n, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mid_tie_rdy0", req0_ready, 1);
    check("mid_tie_rdy1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

`ifdef REVERSAL_GRANT_CNT_EN
    rst_n = 1'b0;
    #1;
    check("cnt_rst0", grant_cnt0, 0);
    check("cnt_rst1", grant_cnt1, 0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h5A;
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (!req0_ready && n < 40) begin
        tick();
        n++;
      end
      tick();
      if (i == 0) check("cnt_one", grant_cnt0, 1);
    end
    req0_valid = 1'b0;
    wait_valid(n);
    tick();
    check("cnt_wrap0", grant_cnt0, 0);
    check("cnt_stay1", grant_cnt1, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reversal_arbiter.md
REVERSAL_ARBITER -- requirements
Module: reversal_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, bit width of each data word; legal values are WIDTH >= 2.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req0_valid  input  1; req0_data  input  WIDTH; req0_ready  output  1.
- Together these form requester 0's valid/ready channel.
REQ-005 SHALL have ports: req1_valid  input  1; req1_data  input  WIDTH; req1_ready  output  1.
- Together these form requester 1's valid/ready channel.
REQ-006 SHALL have ports: out_valid  output  1; out_data  output  WIDTH; out_id  output  1; out_ready  input  1.
- Together these form the result channel; out_id names the source requester.
REQ-007 SHALL have port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-008 SHALL share one bit-serial reversal datapath between the two requesters.
- Result definition: out_data[i] = captured word[WIDTH-1-i].
REQ-009 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-010 SHALL, in IDLE, assert reqN_ready combinationally only for the selected requester; both readys SHALL be 0 in SHIFT and DONE.
REQ-011 SHALL select requesters in IDLE as follows:
- only one valid -> select that one;
- both valid -> select the requester not granted last (round-robin);
- last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-012 SHALL, on the accept edge (reqN_valid & reqN_ready), do all of the following:
- capture reqN_data into the source register;
- record the id and update last_grant;
- clear the result register and bit counter;
- move to SHIFT.
REQ-013 SHALL, each SHIFT cycle, update result <= {result[WIDTH-2:0], src[0]} and src <= src >> 1, and increment the counter.
REQ-014 SHALL leave SHIFT after exactly WIDTH cycles and enter DONE.
REQ-015 SHALL assert out_valid only in DONE, with out_data and out_id held stable until out_ready is sampled high.
REQ-016 SHALL, on out_valid & out_ready, return to IDLE.
- No new request is accepted in that same cycle.
- Minimum period is WIDTH+2 cycles per word.
REQ-017 SHALL raise out_valid in the (WIDTH+1)th cycle after the accept edge; for WIDTH=8 this is 9 cycles.
REQ-018 SHALL tolerate a requester dropping valid before it is granted; no state change results.
REQ-019 SHALL drive out_data and out_id to 0 whenever out_valid is 0.

Reset
REQ-020 SHALL, while rst_n is low, asynchronously force all of the following:
- state=IDLE, last_grant=1;
- src, result and counter to 0, out_id=0;
- out_valid=0, busy=0, both readys=0.
REQ-021 SHALL discard any in-flight word when reset is asserted mid-SHIFT or mid-DONE; no result is emitted afterwards.
REQ-022 SHALL resume arbitration on the first rising clk edge after rst_n deasserts.

Configuration
REQ-023 SHALL, with macro REVERSAL_GRANT_CNT_EN defined, add outputs grant_cnt0 and grant_cnt1 (output, 8 bits each).
- Each counter increments on its requester's accept edge.
- Each wraps 255->0 and resets to 0.
REQ-024 SHALL, without REVERSAL_GRANT_CNT_EN, omit those ports and counters entirely; all other behaviour is identical.

Verification
REQ-025 SHALL check single request: req0_data=0x01 with out_ready=1 -> out_data=0x80, out_id=0, out_valid 9 cycles after the accept edge.
REQ-026 SHALL check the tie after reset: req0_data=0x0F and req1_data=0x33, both valid -> 0xF0/id0 first, then 0xCC/id1.
REQ-027 SHALL check round-robin fairness: 4 words per requester, both valid continuously -> ids alternate 0,1,0,1...
REQ-028 SHALL check backpressure: req1_data=0xA0, out_ready=0 for 5 cycles -> out_valid and out_data=0x05 held stable, busy=1, both readys=0.
REQ-029 SHALL check reset mid-SHIFT: rst_n low at shift cycle 3 -> busy=0 and out_valid=0 immediately; no output follows; the next tie is granted to requester 0.
REQ-030 SHALL check counters (REVERSAL_GRANT_CNT_EN defined): 256 grants to requester 0 -> grant_cnt0 wraps to 0 and grant_cnt1 stays 0.
